// File: rtl/capture_buffer.sv
// Capture buffer: records samples into a circular RAM while armed, then after the
// trigger and post-trigger count, streams the window newest-first to the UART byte by byte.
module capture_buffer #(
    parameter int unsigned SAMPLE_WIDTH = 8,
    parameter int unsigned DEPTH_LOG2   = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    run,
    input  logic                    valid_in,
    input  logic [SAMPLE_WIDTH-1:0] data_in,
    input  logic [DEPTH_LOG2:0]     read_count,
    input  logic [DEPTH_LOG2:0]     delay_count,
    input  logic                    tx_busy,
    output logic [7:0]              tran_data,
    output logic                    tran_en,
    output logic                    buffer_busy,
    output logic                    capture_done
);

    localparam int unsigned NumBytes = (SAMPLE_WIDTH + 7) / 8;
    localparam int unsigned ByteIdxW = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam int unsigned Depth    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DepthCnt = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        StIdle, StArmed, StPost, StReadStart, StFetch, StSend, StWaitHi, StWaitLo
    } state_e;

    state_e                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     fill_q, fill_d;
    logic [DEPTH_LOG2:0]     rc_q, rc_d;
    logic [DEPTH_LOG2:0]     dc_q, dc_d;
    logic [DEPTH_LOG2:0]     post_cnt_q, post_cnt_d;
    logic [DEPTH_LOG2:0]     rem_q, rem_d;
    logic [ByteIdxW-1:0]     byte_idx_q, byte_idx_d;
    logic [7:0]              tran_data_q, tran_data_d;
    logic                    tran_en_q, tran_en_d;
    logic                    done_q, done_d;

    logic [SAMPLE_WIDTH-1:0] mem [Depth];
    logic [SAMPLE_WIDTH-1:0] ram_q;
    logic [NumBytes*8-1:0]   sample_pad;
    logic [DEPTH_LOG2:0]     n_avail;
    logic                    we;

    function automatic logic [DEPTH_LOG2:0] clamp_depth(input logic [DEPTH_LOG2:0] v);
        return (v > DepthCnt) ? DepthCnt : v;
    endfunction

    // Writes only happen while capture is enabled; an arm drop in the same cycle aborts first.
    assign we         = valid_in && arm && (state_q == StArmed || state_q == StPost);
    assign n_avail    = (rc_q < fill_q) ? rc_q : fill_q;
    assign sample_pad = (NumBytes*8)'(ram_q);

    // Address stays fixed from FETCH through the last byte, so ram_q holds the sample.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_ptr_q] <= data_in;
        end
        ram_q <= mem[rd_ptr_q];
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        rc_d        = rc_q;
        dc_d        = dc_q;
        post_cnt_d  = post_cnt_q;
        rem_d       = rem_q;
        byte_idx_d  = byte_idx_q;
        tran_data_d = tran_data_q;
        tran_en_d   = 1'b0;
        done_d      = 1'b0;

        if (we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != DepthCnt) begin
                fill_d = fill_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    rc_d     = clamp_depth(read_count);
                    dc_d     = clamp_depth(delay_count);
                    wr_ptr_d = '0;
                    fill_d   = '0;
                    state_d  = StArmed;
                end
            end
            StArmed: begin
                if (!arm) begin
                    state_d = StIdle;
                end else if (run) begin
                    post_cnt_d = '0;
                    state_d    = (dc_q == '0) ? StReadStart : StPost;
                end
            end
            StPost: begin
                if (!arm) begin
                    state_d = StIdle;
                end else if (valid_in) begin
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_q + 1'b1 == dc_q) begin
                        state_d = StReadStart;
                    end
                end
            end
            StReadStart: begin
                rd_ptr_d   = wr_ptr_q - 1'b1;
                byte_idx_d = '0;
                if (n_avail == '0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    rem_d   = n_avail;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StSend;
            end
            StSend: begin
                if (!tx_busy) begin
                    tran_data_d = sample_pad[{byte_idx_q, 3'b000} +: 8];
                    tran_en_d   = 1'b1;
                    state_d     = StWaitHi;
                end
            end
            StWaitHi: begin
                if (tx_busy) begin
                    state_d = StWaitLo;
                end
            end
            StWaitLo: begin
                if (!tx_busy) begin
                    if (byte_idx_q == ByteIdxW'(NumBytes - 1)) begin
                        byte_idx_d = '0;
                        rem_d      = rem_q - 1'b1;
                        rd_ptr_d   = rd_ptr_q - 1'b1;
                        if (rem_q == (DEPTH_LOG2+1)'(1)) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StFetch;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            rc_q        <= '0;
            dc_q        <= '0;
            post_cnt_q  <= '0;
            rem_q       <= '0;
            byte_idx_q  <= '0;
            tran_data_q <= '0;
            tran_en_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            rc_q        <= rc_d;
            dc_q        <= dc_d;
            post_cnt_q  <= post_cnt_d;
            rem_q       <= rem_d;
            byte_idx_q  <= byte_idx_d;
            tran_data_q <= tran_data_d;
            tran_en_q   <= tran_en_d;
            done_q      <= done_d;
        end
    end

    assign tran_data    = tran_data_q;
    assign tran_en      = tran_en_q;
    assign capture_done = done_q;
    assign buffer_busy  = (state_q != StIdle);

endmodule
